// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: turns stall-unit requests and branch resolution into
// PC/IF/ID/ID/EX register controls. Optional perf counters are built under PIPE_STALL_PERF_EN.
module pipe_stall_ctrl #(
  parameter int unsigned MAX_STALL = 16,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_stall_req_i,
  input  logic             id_stall_req_i,
  input  logic             br_resolved_i,
  input  logic             br_taken_i,
  output logic             pc_we_o,
  output logic             pc_sel_br_o,
  output logic             ifid_we_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             stall_timeout_o,
  output logic [CNT_W-1:0] cnt_data_stall_o,
  output logic [CNT_W-1:0] cnt_br_stall_o
);

  localparam logic [7:0] MaxStall = 8'(MAX_STALL);

  typedef enum logic [0:0] {StRun, StBrWait} state_e;

  state_e     state_q, state_d;
  logic [7:0] stall_cnt_q, stall_cnt_d;
  logic       timeout_q, timeout_d;

  always_comb begin
    state_d       = state_q;
    pc_we_o       = 1'b1;
    pc_sel_br_o   = 1'b0;
    ifid_we_o     = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    if (!rst_n) begin
      // Hold everything and feed NOPs while reset is asserted.
      pc_we_o       = 1'b0;
      ifid_we_o     = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (id_stall_req_i) begin
      // Data hazard wins in both states; a coincident branch resolution is dropped.
      pc_we_o       = 1'b0;
      ifid_we_o     = 1'b0;
      idex_bubble_o = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (if_stall_req_i) begin
            pc_we_o      = 1'b0;
            ifid_flush_o = 1'b1;
            state_d      = StBrWait;
          end
        end
        StBrWait: begin
          ifid_flush_o = 1'b1;
          if (br_resolved_i) begin
            pc_sel_br_o = br_taken_i;
            state_d     = StRun;
          end else begin
            pc_we_o = 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = 8'd0;
    if (!pc_we_o) begin
      stall_cnt_d = (stall_cnt_q == 8'hFF) ? 8'hFF : stall_cnt_q + 8'd1;
    end
    timeout_d = timeout_q | (stall_cnt_d >= MaxStall);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      stall_cnt_q <= 8'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign stall_timeout_o = timeout_q;

`ifdef PIPE_STALL_PERF_EN
  logic [CNT_W-1:0] cnt_data_q, cnt_data_d;
  logic [CNT_W-1:0] cnt_br_q, cnt_br_d;
  logic             br_inc;

  // Branch-stall cycles: the entry cycle plus unresolved BRWAIT cycles not masked by a data stall.
  assign br_inc = !id_stall_req_i &&
                  (((state_q == StRun) && if_stall_req_i) ||
                   ((state_q == StBrWait) && !br_resolved_i));

  always_comb begin
    cnt_data_d = cnt_data_q;
    cnt_br_d   = cnt_br_q;
    if (id_stall_req_i && (cnt_data_q != '1)) begin
      cnt_data_d = cnt_data_q + CNT_W'(1);
    end
    if (br_inc && (cnt_br_q != '1)) begin
      cnt_br_d = cnt_br_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_data_q <= '0;
      cnt_br_q   <= '0;
    end else begin
      cnt_data_q <= cnt_data_d;
      cnt_br_q   <= cnt_br_d;
    end
  end

  assign cnt_data_stall_o = cnt_data_q;
  assign cnt_br_stall_o   = cnt_br_q;
`else
  assign cnt_data_stall_o = '0;
  assign cnt_br_stall_o   = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: expected control vectors are queued per driven cycle
// and popped when the outputs are sampled mid-cycle.
module tb_pipe_stall_ctrl;

  localparam int unsigned CntW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            if_stall_req = 1'b0;
  logic            id_stall_req = 1'b0;
  logic            br_resolved = 1'b0;
  logic            br_taken = 1'b0;
  logic            pc_we, pc_sel_br, ifid_we, ifid_flush, idex_bubble, stall_timeout;
  logic [CntW-1:0] cnt_data_stall, cnt_br_stall;

  int total = 0;
  int bad   = 0;

  // {pc_we, pc_sel_br, ifid_we, ifid_flush, idex_bubble, stall_timeout}
  localparam logic [5:0] ERun  = 6'b101000;
  localparam logic [5:0] EDs   = 6'b000010;
  localparam logic [5:0] EBr   = 6'b001100;
  localparam logic [5:0] ETk   = 6'b111100;
  localparam logic [5:0] ENt   = 6'b101100;
  localparam logic [5:0] ERst  = 6'b000110;

`ifdef PIPE_STALL_PERF_EN
  localparam logic [CntW-1:0] ExpPerf = 2;
`else
  localparam logic [CntW-1:0] ExpPerf = 0;
`endif

  // in = {if_stall_req, id_stall_req, br_resolved, br_taken}
  typedef struct packed {
    logic [3:0] in;
    logic [5:0] exp;
  } stim_t;

  logic [5:0] sb[$];

  always #5 clk = ~clk;

  pipe_stall_ctrl #(
    .MAX_STALL(4),
    .CNT_W    (CntW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .if_stall_req_i  (if_stall_req),
    .id_stall_req_i  (id_stall_req),
    .br_resolved_i   (br_resolved),
    .br_taken_i      (br_taken),
    .pc_we_o         (pc_we),
    .pc_sel_br_o     (pc_sel_br),
    .ifid_we_o       (ifid_we),
    .ifid_flush_o    (ifid_flush),
    .idex_bubble_o   (idex_bubble),
    .stall_timeout_o (stall_timeout),
    .cnt_data_stall_o(cnt_data_stall),
    .cnt_br_stall_o  (cnt_br_stall)
  );

  function automatic logic [5:0] obs();
    return {pc_we, pc_sel_br, ifid_we, ifid_flush, idex_bubble, stall_timeout};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    {if_stall_req, id_stall_req, br_resolved, br_taken} = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [5:0] e;
    @(negedge clk);
    rst_n = 1'b0;
    {if_stall_req, id_stall_req, br_resolved, br_taken} = 4'b0110;
    sb.push_back(ERst);
    #2;
    e = sb.pop_front();
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=%b", obs(), e);
    end
    total++;
    if ({cnt_data_stall, cnt_br_stall} !== '0) begin
      bad++;
      $display("FAIL reset_counters got=%0d/%0d want=0/0", cnt_data_stall, cnt_br_stall);
    end
    {if_stall_req, id_stall_req, br_resolved, br_taken} = 4'b0000;
  endtask

  task automatic test_run_idle();
    stim_t t[4];
    logic [5:0] e;
    t[0] = {4'b0000, ERun};
    t[1] = {4'b0000, ERun};
    t[2] = {4'b0000, ERun};
    t[3] = {4'b0011, ERun};  // br_resolved in RUN must not redirect
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      {if_stall_req, id_stall_req, br_resolved, br_taken} = t[i].in;
      sb.push_back(t[i].exp);
      #2;
      e = sb.pop_front();
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL run_idle[%0d] got=%b want=%b", i, obs(), e);
      end
    end
  endtask

  task automatic test_data_stall();
    stim_t t[5];
    logic [5:0] e;
    t[0] = {4'b0100, EDs};
    t[1] = {4'b0100, EDs};
    t[2] = {4'b0000, ERun};
    t[3] = {4'b1100, EDs};   // id stall beats if stall, state stays RUN
    t[4] = {4'b0000, ERun};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      {if_stall_req, id_stall_req, br_resolved, br_taken} = t[i].in;
      sb.push_back(t[i].exp);
      #2;
      e = sb.pop_front();
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL data_stall[%0d] got=%b want=%b", i, obs(), e);
      end
    end
  endtask

  task automatic test_branch();
    stim_t t[7];
    logic [5:0] e;
    t[0] = {4'b1000, EBr};
    t[1] = {4'b0000, EBr};
    t[2] = {4'b0011, ETk};
    t[3] = {4'b0000, ERun};
    t[4] = {4'b1000, EBr};
    t[5] = {4'b0010, ENt};   // not-taken still flushes, PC+4
    t[6] = {4'b0000, ERun};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      {if_stall_req, id_stall_req, br_resolved, br_taken} = t[i].in;
      sb.push_back(t[i].exp);
      #2;
      e = sb.pop_front();
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL branch[%0d] got=%b want=%b", i, obs(), e);
      end
    end
  endtask

  task automatic test_brwait_data_stall();
    stim_t t[5];
    logic [5:0] e;
    t[0] = {4'b1000, EBr};
    t[1] = {4'b0111, EDs};   // resolution dropped under data stall
    t[2] = {4'b0000, EBr};   // still waiting
    t[3] = {4'b0011, ETk};
    t[4] = {4'b0000, ERun};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      {if_stall_req, id_stall_req, br_resolved, br_taken} = t[i].in;
      sb.push_back(t[i].exp);
      #2;
      e = sb.pop_front();
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL brwait_dstall[%0d] got=%b want=%b", i, obs(), e);
      end
    end
  endtask

  task automatic test_perf();
    stim_t t[7];
    logic [5:0] e;
    t[0] = {4'b1000, EBr};
    t[1] = {4'b0000, EBr};
    t[2] = {4'b0011, ETk};
    t[3] = {4'b0000, ERun};
    t[4] = {4'b0100, EDs};
    t[5] = {4'b0100, EDs};
    t[6] = {4'b0000, ERun};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      {if_stall_req, id_stall_req, br_resolved, br_taken} = t[i].in;
      sb.push_back(t[i].exp);
      #2;
      e = sb.pop_front();
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL perf_seq[%0d] got=%b want=%b", i, obs(), e);
      end
    end
    @(negedge clk);
    {if_stall_req, id_stall_req, br_resolved, br_taken} = 4'b0000;
    #2;
    total++;
    if (cnt_br_stall !== ExpPerf) begin
      bad++;
      $display("FAIL cnt_br_stall got=%0d want=%0d", cnt_br_stall, ExpPerf);
    end
    total++;
    if (cnt_data_stall !== ExpPerf) begin
      bad++;
      $display("FAIL cnt_data_stall got=%0d want=%0d", cnt_data_stall, ExpPerf);
    end
  endtask

  task automatic test_async_reset();
    logic [5:0] e;
    do_reset();
    @(negedge clk);
    if_stall_req = 1'b1;
    @(negedge clk);
    if_stall_req = 1'b0;
    sb.push_back(EBr);
    #2;
    e = sb.pop_front();
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL async_pre got=%b want=%b", obs(), e);
    end
    #1;
    rst_n = 1'b0;              // asserted away from any clock edge
    sb.push_back(ERst);
    #1;
    e = sb.pop_front();
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL async_during got=%b want=%b", obs(), e);
    end
    total++;
    if ({cnt_data_stall, cnt_br_stall} !== '0) begin
      bad++;
      $display("FAIL async_counters got=%0d/%0d want=0/0", cnt_data_stall, cnt_br_stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    br_resolved = 1'b1;        // a stale redirect would show here if BRWAIT survived
    br_taken    = 1'b1;
    sb.push_back(ERun);
    #2;
    e = sb.pop_front();
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL async_post got=%b want=%b", obs(), e);
    end
    br_resolved = 1'b0;
    br_taken    = 1'b0;
  endtask

  task automatic test_timeout();
    stim_t t[8];
    logic [5:0] e;
    t[0] = {4'b0100, EDs};
    t[1] = {4'b0100, EDs};
    t[2] = {4'b0100, EDs};
    t[3] = {4'b0100, EDs};
    t[4] = {4'b0100, EDs | 6'b000001};  // counter hit 4 at the previous edge
    t[5] = {4'b0100, EDs | 6'b000001};
    t[6] = {4'b0000, ERun | 6'b000001};
    t[7] = {4'b0000, ERun | 6'b000001};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      {if_stall_req, id_stall_req, br_resolved, br_taken} = t[i].in;
      sb.push_back(t[i].exp);
      #2;
      e = sb.pop_front();
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL timeout[%0d] got=%b want=%b", i, obs(), e);
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    {if_stall_req, id_stall_req, br_resolved, br_taken} = 4'b0000;
    sb.push_back(ERst);
    #2;
    e = sb.pop_front();
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL timeout_clear got=%b want=%b", obs(), e);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(ERun);
    #2;
    e = sb.pop_front();
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL timeout_after_rst got=%b want=%b", obs(), e);
    end
  endtask

  initial begin
    test_reset();
    test_run_idle();
    test_data_stall();
    test_branch();
    test_brwait_data_stall();
    test_perf();
    test_async_reset();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
